input_decoder: RTL and testbench
================================

INPUT_DECODER -- requirements
Module: input_decoder

Interface
REQ-001 Parameter RANGE_WIDTH, default 49, width of every decoded range bound.
REQ-002 Parameter BYTE_WIDTH, default 8, width of the inbound byte.
REQ-003 The design SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 inbound_valid  input  1  qualifies inbound_byte for one cycle.
REQ-007 inbound_byte  input  BYTE_WIDTH  ASCII character of the puzzle input stream.
REQ-008 end_of_file  output  1  sticky flag; the range section is complete.
REQ-009 range_valid  output  1  single-cycle pulse; range_data holds one bound.
REQ-010 range_data  output  RANGE_WIDTH  decoded bound, unsigned binary.

Function
REQ-011 Input grammar: lines "LO-HI" then LF, then a blank line ends the range section; any bytes after it are ignored.
REQ-012 Cycles with inbound_valid low SHALL change no state; idle gaps of any length are legal.
REQ-013 FSM states: S_LO (accumulate lower bound), S_HI (accumulate upper bound), S_DONE.
REQ-014 Digit '0'..'9' in S_LO/S_HI: acc <= acc*10 + digit, truncated modulo 2^RANGE_WIDTH; set digit_seen.
REQ-015 '-' in S_LO with digit_seen: emit acc, clear acc/digit_seen, go to S_HI; '-' without digits or in S_HI is ignored.
REQ-016 LF in S_HI with digit_seen: emit acc, clear acc/digit_seen, go to S_LO; LF in S_HI without digits: discard line, go to S_LO.
REQ-017 LF in S_LO with no character other than CR since the previous LF (or since reset): go to S_DONE and assert end_of_file.
REQ-018 LF in S_LO after digits without '-' (malformed line): discard acc, stay in S_LO, no emit.
REQ-019 CR (0x0D) SHALL be ignored everywhere and SHALL NOT make a line non-blank; other non-grammar bytes are ignored.
REQ-020 Emission: range_valid high for exactly one cycle, the cycle after the terminating byte is sampled; range_data valid in that cycle and holds its value until the next emission.
REQ-021 Bounds SHALL be emitted strictly in order: lower then upper of each range; no backpressure exists.
REQ-022 end_of_file rises the cycle after the blank-line LF and stays high until reset; S_DONE is terminal, and no range_valid is produced in it.

Reset
REQ-023 rst_n low SHALL immediately force S_LO, acc=0, digit_seen=0, line-blank flag set, range_valid=0, range_data=0, end_of_file=0.
REQ-024 Reset asserted mid-line SHALL discard partial numbers; parsing restarts at the first byte after release.

Structure
REQ-025 A shared package SHALL hold RANGE_WIDTH default, BYTE_WIDTH, ASCII constants (0x30-0x39, 0x2D, 0x0A, 0x0D) and the FSM state enum.
REQ-026 Multiply-by-10 SHALL be (acc<<3)+(acc<<1); no DSP inference required.
REQ-027 One sub-module is natural: dec_accumulator (clear, digit strobe, RANGE_WIDTH accumulator).

Verification
REQ-028 "3-5\n" -> two range_valid pulses, data 3 then 5, each one cycle after '-' and LF respectively.
REQ-029 "3-5\n10-14\n\n" -> pulses 3,5,10,14; end_of_file high one cycle after the final LF and held.
REQ-030 "562949953421311-562949953421312\n" -> 0x1FFFFFFFFFFFF, then 0 (wrap at 2^49).
REQ-031 "12-34\r\n\r\n" with random inbound_valid gaps -> 12, 34, then end_of_file; CR never emits.
REQ-032 After end_of_file, "5\n7-8\n" -> no range_valid; end_of_file stays 1.
REQ-033 "12" then rst_n pulse, then "7-9\n" -> only 7 and 9 emitted; all outputs 0 during reset.

Source files
------------

// File: rtl/input_decoder_pkg.sv
// Shared definitions for the puzzle-input range decoder.
//   - default widths for decoded bounds and inbound bytes
//   - ASCII codes recognised by the line grammar "LO-HI\n"
//   - parser FSM state encoding
package input_decoder_pkg;

  localparam int RANGE_WIDTH_DEF = 49;
  localparam int BYTE_WIDTH_DEF  = 8;

  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_9    = 8'h39;
  localparam logic [7:0] CHAR_DASH = 8'h2D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_CR   = 8'h0D;

  // S_LO: accumulating lower bound, S_HI: upper bound, S_DONE: range section over
  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/input_decoder_dec_accumulator.sv
// Decimal accumulator: acc <= acc*10 + digit on each digit strobe.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         zero the accumulator (wins over digit_strobe)
//   digit_strobe  fold digit into the accumulator
//   digit         binary value 0..9 of the decimal digit
//   acc           current accumulated value, modulo 2^RANGE_WIDTH
module dec_accumulator #(
  parameter int RANGE_WIDTH = 49
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   digit_strobe,
  input  logic [3:0]             digit,
  output logic [RANGE_WIDTH-1:0] acc
);

  logic [RANGE_WIDTH-1:0] acc_times10;

  // x*10 as two shifts and an add; overflow bits simply fall off the top
  assign acc_times10 = (acc << 3) + (acc << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (digit_strobe) begin
      acc <= acc_times10 + RANGE_WIDTH'(digit);
    end
  end

endmodule

// File: rtl/input_decoder.sv
// Parses an ASCII stream of "LO-HI" lines into a sequence of bounds.
// A blank line (only CRs allowed before its LF) ends the range section.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   inbound_valid  byte strobe; inbound_byte is consumed in every cycle it is
//                  high. There is no ready: the decoder accepts one byte per
//                  cycle unconditionally, and range_valid is a one-cycle pulse
//                  that the consumer must take when it appears.
//   inbound_byte   ASCII character
//   end_of_file    sticky, set the cycle after the blank-line LF
//   range_valid    one-cycle pulse, range_data carries one bound (LO then HI)
//   range_data     last emitted bound, held between pulses
module input_decoder
  import input_decoder_pkg::*;
#(
  parameter int RANGE_WIDTH = RANGE_WIDTH_DEF,
  parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inbound_valid,
  input  logic [BYTE_WIDTH-1:0]  inbound_byte,
  output logic                   end_of_file,
  output logic                   range_valid,
  output logic [RANGE_WIDTH-1:0] range_data
);

  state_t                 state, state_n;
  logic                   digit_seen, digit_seen_n;
  logic                   line_blank, line_blank_n;
  logic                   acc_clear, acc_strobe, emit, eof_set;
  logic [RANGE_WIDTH-1:0] acc;

  logic is_digit, is_dash, is_lf, is_cr;

  assign is_digit = (inbound_byte >= BYTE_WIDTH'(CHAR_0)) &&
                    (inbound_byte <= BYTE_WIDTH'(CHAR_9));
  assign is_dash  = (inbound_byte == BYTE_WIDTH'(CHAR_DASH));
  assign is_lf    = (inbound_byte == BYTE_WIDTH'(CHAR_LF));
  assign is_cr    = (inbound_byte == BYTE_WIDTH'(CHAR_CR));

  dec_accumulator #(
    .RANGE_WIDTH (RANGE_WIDTH)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (acc_clear),
    .digit_strobe (acc_strobe),
    .digit        (inbound_byte[3:0]),
    .acc          (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LO;
      digit_seen  <= 1'b0;
      line_blank  <= 1'b1;
      range_valid <= 1'b0;
      range_data  <= '0;
      end_of_file <= 1'b0;
    end else begin
      state       <= state_n;
      digit_seen  <= digit_seen_n;
      line_blank  <= line_blank_n;
      range_valid <= emit;
      // acc is cleared in the same cycle, so capture its pre-clear value here
      if (emit) begin
        range_data <= acc;
      end
      if (eof_set) begin
        end_of_file <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    digit_seen_n = digit_seen;
    line_blank_n = line_blank;
    acc_clear    = 1'b0;
    acc_strobe   = 1'b0;
    emit         = 1'b0;
    eof_set      = 1'b0;

    if (inbound_valid) begin
      case (state)
        S_LO: begin
          if (is_digit) begin
            acc_strobe   = 1'b1;
            digit_seen_n = 1'b1;
            line_blank_n = 1'b0;
          end else if (is_dash) begin
            line_blank_n = 1'b0;
            if (digit_seen) begin
              emit         = 1'b1;
              acc_clear    = 1'b1;
              digit_seen_n = 1'b0;
              state_n      = S_HI;
            end
          end else if (is_lf) begin
            if (line_blank) begin
              eof_set = 1'b1;
              state_n = S_DONE;
            end else begin
              // malformed line without '-': drop whatever was gathered
              acc_clear    = 1'b1;
              digit_seen_n = 1'b0;
              line_blank_n = 1'b1;
            end
          end else if (!is_cr) begin
            // junk is ignored but still means the line is not blank
            line_blank_n = 1'b0;
          end
        end
        S_HI: begin
          if (is_digit) begin
            acc_strobe   = 1'b1;
            digit_seen_n = 1'b1;
          end else if (is_lf) begin
            emit         = digit_seen;
            acc_clear    = 1'b1;
            digit_seen_n = 1'b0;
            line_blank_n = 1'b1;
            state_n      = S_LO;
          end
        end
        default: begin
          // S_DONE is terminal until reset
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_decoder.sv
module tb_input_decoder;
  import input_decoder_pkg::*;

  localparam int RW = 49;
  localparam int BW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inbound_valid = 1'b0;
  logic [BW-1:0] inbound_byte = '0;
  logic          end_of_file;
  logic          range_valid;
  logic [RW-1:0] range_data;

  always #5 clk = ~clk;

  input_decoder #(
    .RANGE_WIDTH (RW),
    .BYTE_WIDTH  (BW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inbound_valid (inbound_valid),
    .inbound_byte  (inbound_byte),
    .end_of_file   (end_of_file),
    .range_valid   (range_valid),
    .range_data    (range_data)
  );

  // ---------------- scoreboard state ----------------
  int            tests = 0;
  int            fails = 0;
  logic [RW-1:0] exp_q[$];
  logic          eof_prev = 1'b0;

  // ---------------- vector table ----------------
  typedef struct {
    string         txt;
    int            gap;
    int            n;
    logic [RW-1:0] e[4];
    logic          eof;
  } vec_t;

  vec_t vecs[9];

  task automatic set_vec(input int idx, input string txt, input int gap, input int n,
                         input logic [RW-1:0] e0, input logic [RW-1:0] e1,
                         input logic [RW-1:0] e2, input logic [RW-1:0] e3,
                         input logic eof);
    vecs[idx].txt  = txt;
    vecs[idx].gap  = gap;
    vecs[idx].n    = n;
    vecs[idx].e[0] = e0;
    vecs[idx].e[1] = e1;
    vecs[idx].e[2] = e2;
    vecs[idx].e[3] = e3;
    vecs[idx].eof  = eof;
  endtask

  // ---------------- output checks after each sampled cycle ----------------
  // Called at posedge+1: outputs reflect the byte (v,b) just sampled.
  task automatic check_outputs(input logic v, input logic [BW-1:0] b);
    logic [RW-1:0] exp;
    if (range_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse got=%0h want=no pulse", range_data);
      end else begin
        exp = exp_q.pop_front();
        if (range_data !== exp) begin
          fails++;
          $display("FAIL range_data got=%0h want=%0h", range_data, exp);
        end
      end
      tests++;
      if (!(v && (b == CHAR_DASH || b == CHAR_LF))) begin
        fails++;
        $display("FAIL pulse_timing got byte v=%0b b=%0h want '-' or LF", v, b);
      end
    end
    if (end_of_file !== eof_prev) begin
      tests++;
      if (!(end_of_file && v && b == CHAR_LF)) begin
        fails++;
        $display("FAIL eof_edge got eof=%0b after v=%0b b=%0h want rise after LF",
                 end_of_file, v, b);
      end
    end
    eof_prev = end_of_file;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [BW-1:0] b);
    inbound_valid = v;
    inbound_byte  = b;
    @(posedge clk);
    #1;
    check_outputs(v, b);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      repeat ($urandom_range(0, gap)) cycle(1'b0, 8'h00);
      cycle(1'b1, s[i]);
    end
    inbound_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({range_valid, end_of_file, range_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got valid=%0b eof=%0b data=%0h want all 0",
               range_valid, end_of_file, range_data);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    eof_prev = 1'b0;
  endtask

  task automatic finish_case(input string name, input logic exp_eof, input logic [RW-1:0] exp_hold);
    repeat (3) cycle(1'b0, 8'h00);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s missing_pulses got=%0d left want=0", name, exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (end_of_file !== exp_eof) begin
      fails++;
      $display("FAIL %s eof got=%0b want=%0b", name, end_of_file, exp_eof);
    end
    tests++;
    if (range_data !== exp_hold) begin
      fails++;
      $display("FAIL %s data_hold got=%0h want=%0h", name, range_data, exp_hold);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    set_vec(0, "3-5\n", 0, 2, 49'd3, 49'd5, 0, 0, 1'b0);
    set_vec(1, "3-5\n10-14\n\n", 0, 4, 49'd3, 49'd5, 49'd10, 49'd14, 1'b1);
    set_vec(2, "562949953421311-562949953421312\n", 0, 2, 49'h1FFFFFFFFFFFF, 49'd0, 0, 0, 1'b0);
    set_vec(3, "12-34\015\n\015\n", 3, 2, 49'd12, 49'd34, 0, 0, 1'b1);
    set_vec(4, "-5\n", 1, 0, 0, 0, 0, 0, 1'b0);
    set_vec(5, "7-\n1-2\n", 0, 3, 49'd7, 49'd1, 49'd2, 0, 1'b0);
    set_vec(6, "4-5-6\n", 2, 2, 49'd4, 49'd56, 0, 0, 1'b0);
    set_vec(7, "\n", 0, 0, 0, 0, 0, 0, 1'b1);
    set_vec(8, "x\n1-2\n\n", 1, 2, 49'd1, 49'd2, 0, 0, 1'b1);

    for (int c = 0; c < 9; c++) begin
      logic [RW-1:0] hold;
      do_reset();
      for (int k = 0; k < vecs[c].n; k++) exp_q.push_back(vecs[c].e[k]);
      hold = (vecs[c].n > 0) ? vecs[c].e[vecs[c].n-1] : '0;
      send_str(vecs[c].txt, vecs[c].gap);
      finish_case($sformatf("vec%0d", c), vecs[c].eof, hold);
    end

    // Bytes after end of range section are ignored
    do_reset();
    exp_q.push_back(49'd1);
    exp_q.push_back(49'd2);
    send_str("1-2\n\n", 0);
    send_str("5\n7-8\n", 1);
    finish_case("after_eof", 1'b1, 49'd2);

    // Reset mid-line drops the partial number
    do_reset();
    exp_q.push_back(49'd3);
    exp_q.push_back(49'd4);
    send_str("3-4\n12", 0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({range_valid, end_of_file, range_data} !== '0) begin
      fails++;
      $display("FAIL async_reset got valid=%0b eof=%0b data=%0h want all 0",
               range_valid, end_of_file, range_data);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({range_valid, end_of_file, range_data} !== '0) begin
      fails++;
      $display("FAIL held_reset got valid=%0b eof=%0b data=%0h want all 0",
               range_valid, end_of_file, range_data);
    end
    rst_n    = 1'b1;
    eof_prev = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pre_reset_pulses got=%0d left want=0", exp_q.size());
      exp_q.delete();
    end
    exp_q.push_back(49'd7);
    exp_q.push_back(49'd9);
    send_str("7-9\n", 0);
    finish_case("reset_midline", 1'b0, 49'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
